// File: rtl/dram_itf_arbiter_if.sv
// Bus bundle for dram_itf_arbiter: core LSU port, external master port and SRAM port.
// The arbiter takes the slave modport; the surrounding logic (or bench) takes the master modport.
interface dram_itf_arbiter_if;
    logic        core_req_i;
    logic        core_we_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wdata_i;
    logic [3:0]  core_be_i;
    logic        core_gnt_o;
    logic        core_rvalid_o;
    logic [31:0] core_rdata_o;

    logic        ext_req_i;
    logic        ext_we_i;
    logic [31:0] ext_addr_i;
    logic [31:0] ext_wdata_i;
    logic [3:0]  ext_be_i;
    logic        ext_ack_o;
    logic [31:0] ext_rdata_o;

    logic        sram_req_o;
    logic        sram_we_o;
    logic [31:0] sram_addr_o;
    logic [31:0] sram_wdata_o;
    logic [3:0]  sram_be_o;
    logic [31:0] sram_rdata_i;

    modport slave (
        input  core_req_i, core_we_i, core_addr_i, core_wdata_i, core_be_i,
        input  ext_req_i, ext_we_i, ext_addr_i, ext_wdata_i, ext_be_i,
        input  sram_rdata_i,
        output core_gnt_o, core_rvalid_o, core_rdata_o,
        output ext_ack_o, ext_rdata_o,
        output sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o
    );

    modport master (
        output core_req_i, core_we_i, core_addr_i, core_wdata_i, core_be_i,
        output ext_req_i, ext_we_i, ext_addr_i, ext_wdata_i, ext_be_i,
        output sram_rdata_i,
        input  core_gnt_o, core_rvalid_o, core_rdata_o,
        input  ext_ack_o, ext_rdata_o,
        input  sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o
    );
endinterface

// File: rtl/dram_itf_arbiter.sv
// Two-port SRAM arbiter: core LSU has priority, external master is served in a 4-state handshake.
// Define DRAM_ARB_STARVE_GUARD_EN to force the external port after STARVE_MAX denied cycles.
module dram_itf_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk_neg_i,
    input  logic              rst_neg_ni,
    dram_itf_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXT_ISSUE, EXT_ACK, EXT_DROP} state_t;

    state_t      state;
    logic [31:0] ext_addr_q;
    logic [31:0] ext_wdata_q;
    logic [3:0]  ext_be_q;
    logic        ext_we_q;
    logic        ext_ack_q;
    logic        rd_vld_p1;

    logic        starve_hit;
    logic        ext_win;
    logic        core_gnt;
    logic        sram_req;
    logic        sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [3:0]  sram_be;

    assign ext_win = (state == IDLE) & bus.ext_req_i & (~bus.core_req_i | starve_hit);

`ifdef DRAM_ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt;

    assign starve_hit = (starve_cnt == 4'(STARVE_MAX));

    always_ff @(posedge clk_neg_i or negedge rst_neg_ni) begin
        if (!rst_neg_ni) begin
            starve_cnt <= '0;
        end else if (ext_win) begin
            starve_cnt <= '0;
        end else if ((state == IDLE) && bus.ext_req_i && bus.core_req_i && !starve_hit) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    logic unused_starve_cfg;

    assign starve_hit        = 1'b0;
    assign unused_starve_cfg = (STARVE_MAX == 0);
`endif

    // Grant is combinational and held low while reset is asserted so outputs sit at reset values.
    always_comb begin
        core_gnt = 1'b0;
        case (state)
            IDLE:              core_gnt = bus.core_req_i & ~ext_win;
            EXT_ACK, EXT_DROP: core_gnt = bus.core_req_i;
            default:           core_gnt = 1'b0;
        endcase
        core_gnt = core_gnt & rst_neg_ni;
    end

    always_ff @(posedge clk_neg_i or negedge rst_neg_ni) begin
        if (!rst_neg_ni) begin
            state       <= IDLE;
            ext_addr_q  <= '0;
            ext_wdata_q <= '0;
            ext_be_q    <= '0;
            ext_we_q    <= 1'b0;
            ext_ack_q   <= 1'b0;
            rd_vld_p1   <= 1'b0;
        end else begin
            rd_vld_p1 <= core_gnt & ~bus.core_we_i;
            ext_ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (ext_win) begin
                        ext_addr_q  <= bus.ext_addr_i;
                        ext_wdata_q <= bus.ext_wdata_i;
                        ext_be_q    <= bus.ext_be_i;
                        ext_we_q    <= bus.ext_we_i;
                        state       <= EXT_ISSUE;
                    end
                end
                EXT_ISSUE: begin
                    ext_ack_q <= 1'b1;
                    state     <= EXT_ACK;
                end
                EXT_ACK: state <= EXT_DROP;
                // The external master holds its request until it sees ack; wait for it to drop.
                EXT_DROP: begin
                    if (!bus.ext_req_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        sram_req   = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        sram_be    = 4'hF;
        if (state == EXT_ISSUE) begin
            sram_req   = 1'b1;
            sram_we    = ext_we_q;
            sram_addr  = ext_addr_q;
            sram_wdata = ext_wdata_q;
            sram_be    = ext_be_q;
        end else if (core_gnt) begin
            sram_req   = 1'b1;
            sram_we    = bus.core_we_i;
            sram_addr  = bus.core_addr_i;
            sram_wdata = bus.core_wdata_i;
            sram_be    = bus.core_be_i;
        end
    end

    assign bus.core_gnt_o    = core_gnt;
    assign bus.core_rvalid_o = rd_vld_p1;
    assign bus.core_rdata_o  = rd_vld_p1 ? bus.sram_rdata_i : 32'h0;
    assign bus.ext_ack_o     = ext_ack_q;
    assign bus.ext_rdata_o   = ext_ack_q ? bus.sram_rdata_i : 32'h0;
    assign bus.sram_req_o    = sram_req;
    assign bus.sram_we_o     = sram_we;
    assign bus.sram_addr_o   = sram_addr;
    assign bus.sram_wdata_o  = sram_wdata;
    assign bus.sram_be_o     = sram_be;
endmodule

// File: tb/tb_dram_itf_arbiter.sv
// Directed bench for dram_itf_arbiter: vector table plus hand-written starvation and reset sequences.
// Expectations for the starvation sequence follow DRAM_ARB_STARVE_GUARD_EN.
module tb_dram_itf_arbiter;
    logic clk_neg_i  = 1'b0;
    logic rst_neg_ni = 1'b0;

    always #5 clk_neg_i = ~clk_neg_i;

    dram_itf_arbiter_if bus ();

    dram_itf_arbiter #(.STARVE_MAX(4)) dut (
        .clk_neg_i  (clk_neg_i),
        .rst_neg_ni (rst_neg_ni),
        .bus        (bus)
    );

    typedef struct {
        logic        c_req;
        logic        c_we;
        logic [31:0] c_addr;
        logic [31:0] c_wdata;
        logic [3:0]  c_be;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
        logic [31:0] s_rdata;
        logic [136:0] exp;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;

    // Packed output order: gnt, rvalid, core_rdata, ack, ext_rdata, sram req/we/addr/wdata/be.
    function automatic logic [136:0] xo(input logic [31:0] g, rv, rd, ak, erd, sq, sw, sa, sd, sb);
        return {g[0], rv[0], rd, ak[0], erd, sq[0], sw[0], sa, sd, sb[3:0]};
    endfunction

    function automatic logic [136:0] outs();
        return {bus.core_gnt_o, bus.core_rvalid_o, bus.core_rdata_o, bus.ext_ack_o, bus.ext_rdata_o,
                bus.sram_req_o, bus.sram_we_o, bus.sram_addr_o, bus.sram_wdata_o, bus.sram_be_o};
    endfunction

    task automatic chk(input string name, input logic [136:0] act, input logic [136:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] cr, cw, ca, cd, cb, er, ew, ea, ed, eb, sr,
                       input logic [136:0] ex);
        vec_t v;
        v.c_req = cr[0]; v.c_we = cw[0]; v.c_addr = ca; v.c_wdata = cd; v.c_be = cb[3:0];
        v.e_req = er[0]; v.e_we = ew[0]; v.e_addr = ea; v.e_wdata = ed; v.e_be = eb[3:0];
        v.s_rdata = sr;
        v.exp = ex;
        vq.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        bus.core_req_i   = v.c_req;
        bus.core_we_i    = v.c_we;
        bus.core_addr_i  = v.c_addr;
        bus.core_wdata_i = v.c_wdata;
        bus.core_be_i    = v.c_be;
        bus.ext_req_i    = v.e_req;
        bus.ext_we_i     = v.e_we;
        bus.ext_addr_i   = v.e_addr;
        bus.ext_wdata_i  = v.e_wdata;
        bus.ext_be_i     = v.e_be;
        bus.sram_rdata_i = v.s_rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [136:0] d;
        vec_t         idle_v;
        int           ack_cyc;
        int           iss_cyc;
        int           gnt_pre;
        int           ack_cnt;
        int           exp_iss;
        int           exp_ack;
        int           exp_gnt;

        d = xo(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hF);
        idle_v = '{default: '0};

        // Reset: requests present on both ports must not leak to outputs.
        drive(idle_v);
        bus.core_req_i = 1'b1;
        bus.ext_req_i  = 1'b1;
        bus.core_addr_i = 32'h44;
        @(negedge clk_neg_i); #2;
        chk("reset_outputs", outs(), d);
        @(negedge clk_neg_i);
        drive(idle_v);
        rst_neg_ni = 1'b1;
        #2;
        chk("after_release", outs(), d);

        //   core req/we/addr/wdata/be           ext req/we/addr/wdata/be                  sram_rdata
        add(0, 0, 0,       0,            0,    0, 0, 0,       0,            0,    32'h5555,     d);
        add(1, 0, 32'h100, 0,            32'hF, 0, 0, 0,      0,            0,    0,
            xo(1, 0, 0, 0, 0, 1, 0, 32'h100, 0, 32'hF));
        add(0, 0, 0,       0,            0,    0, 0, 0,       0,            0,    32'hCAFE0100,
            xo(0, 1, 32'hCAFE0100, 0, 0, 0, 0, 0, 0, 32'hF));
        add(1, 1, 32'h104, 32'h11223344, 32'h3, 0, 0, 0,      0,            0,    32'h77,
            xo(1, 0, 0, 0, 0, 1, 1, 32'h104, 32'h11223344, 32'h3));
        add(0, 0, 0,       0,            0,    0, 0, 0,       0,            0,    32'h99,       d);
        add(0, 0, 0,       0,            0,    1, 1, 32'h200, 32'hDEADBEEF, 32'hF, 0,           d);
        add(0, 0, 0,       0,            0,    1, 1, 32'h200, 32'hDEADBEEF, 32'hF, 0,
            xo(0, 0, 0, 0, 0, 1, 1, 32'h200, 32'hDEADBEEF, 32'hF));
        add(0, 0, 0,       0,            0,    1, 1, 32'h200, 32'hDEADBEEF, 32'hF, 32'h12345678,
            xo(0, 0, 0, 1, 32'h12345678, 0, 0, 0, 0, 32'hF));
        add(0, 0, 0,       0,            0,    1, 1, 32'h200, 32'hDEADBEEF, 32'hF, 0,           d);
        add(0, 0, 0,       0,            0,    1, 1, 32'h200, 32'hDEADBEEF, 32'hF, 0,           d);
        add(0, 0, 0,       0,            0,    0, 0, 0,       0,            0,    0,            d);
        add(0, 0, 0,       0,            0,    0, 0, 0,       0,            0,    0,            d);
        add(0, 0, 0,       0,            0,    1, 0, 32'h300, 0,            32'h6, 0,           d);
        add(1, 0, 32'h400, 0,            32'hF, 1, 0, 32'h300, 0,           32'h6, 0,
            xo(0, 0, 0, 0, 0, 1, 0, 32'h300, 0, 32'h6));
        add(1, 0, 32'h404, 0,            32'hF, 1, 0, 32'h300, 0,           32'h6, 32'hABCD0300,
            xo(1, 0, 0, 1, 32'hABCD0300, 1, 0, 32'h404, 0, 32'hF));
        add(0, 0, 0,       0,            0,    0, 0, 0,       0,            0,    32'h0404DA7A,
            xo(0, 1, 32'h0404DA7A, 0, 0, 0, 0, 0, 0, 32'hF));
        add(0, 0, 0,       0,            0,    0, 0, 0,       0,            0,    0,            d);
        add(1, 0, 32'h500, 0,            32'hF, 1, 0, 32'h600, 0,           32'hF, 0,
            xo(1, 0, 0, 0, 0, 1, 0, 32'h500, 0, 32'hF));
        add(0, 0, 0,       0,            0,    1, 0, 32'h600, 0,            32'hF, 32'h5,
            xo(0, 1, 32'h5, 0, 0, 0, 0, 0, 0, 32'hF));
        add(0, 0, 0,       0,            0,    1, 0, 32'h600, 0,            32'hF, 0,
            xo(0, 0, 0, 0, 0, 1, 0, 32'h600, 0, 32'hF));
        add(0, 0, 0,       0,            0,    0, 0, 0,       0,            0,    32'h600600,
            xo(0, 0, 0, 1, 32'h600600, 0, 0, 0, 0, 32'hF));
        add(0, 0, 0,       0,            0,    0, 0, 0,       0,            0,    0,            d);

        foreach (vq[i]) begin
            @(negedge clk_neg_i);
            drive(vq[i]);
            #2;
            chk($sformatf("vec%0d", i), outs(), vq[i].exp);
        end

        // Starvation: core requests continuously for 12 cycles while ext holds a read.
`ifdef DRAM_ARB_STARVE_GUARD_EN
        exp_gnt = 4;  exp_iss = 5;  exp_ack = 6;
`else
        exp_gnt = 12; exp_iss = 13; exp_ack = 14;
`endif
        ack_cyc = -1; iss_cyc = -1; gnt_pre = 0; ack_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_neg_i);
            drive(idle_v);
            bus.core_req_i  = (c < 12);
            bus.core_addr_i = 32'h700;
            bus.core_be_i   = 4'hF;
            bus.ext_req_i   = (ack_cyc < 0);
            bus.ext_addr_i  = 32'h800;
            bus.ext_be_i    = 4'hF;
            bus.sram_rdata_i = 32'h8008_0000 + 32'(c);
            #2;
            if (bus.sram_req_o && bus.sram_addr_o == 32'h800 && iss_cyc < 0) iss_cyc = c;
            if (bus.core_gnt_o && iss_cyc < 0) gnt_pre++;
            if (bus.ext_ack_o) begin
                ack_cnt++;
                if (ack_cyc < 0) ack_cyc = c;
            end
        end
        chk("starve_gnt_before_issue", 137'(gnt_pre), 137'(exp_gnt));
        chk("starve_issue_cycle", 137'(iss_cyc), 137'(exp_iss));
        chk("starve_ack_cycle", 137'(ack_cyc), 137'(exp_ack));
        chk("starve_ack_count", 137'(ack_cnt), 137'(1));

        // Reset asserted while the external write is being issued.
        @(negedge clk_neg_i);
        drive(idle_v);
        #2;
        chk("pre_rst_idle", outs(), d);
        @(negedge clk_neg_i);
        bus.ext_req_i   = 1'b1;
        bus.ext_we_i    = 1'b1;
        bus.ext_addr_i  = 32'h900;
        bus.ext_wdata_i = 32'hA5A5A5A5;
        bus.ext_be_i    = 4'hF;
        #2;
        chk("rst_seq_req_cycle", outs(), d);
        @(negedge clk_neg_i); #2;
        chk("rst_seq_issue", outs(), xo(0, 0, 0, 0, 0, 1, 1, 32'h900, 32'hA5A5A5A5, 32'hF));
        #1;
        rst_neg_ni = 1'b0;
        #1;
        chk("rst_in_issue", outs(), d);
        bus.ext_req_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_neg_i); #2;
            chk($sformatf("rst_hold%0d", c), outs(), d);
        end
        @(negedge clk_neg_i);
        rst_neg_ni = 1'b1;
        #2;
        chk("rst_release", outs(), d);
        @(negedge clk_neg_i); #2;
        chk("rst_no_late_ack", outs(), d);

        // The external master re-requests after reset and completes normally.
        @(negedge clk_neg_i);
        drive(idle_v);
        bus.ext_req_i  = 1'b1;
        bus.ext_addr_i = 32'h904;
        bus.ext_be_i   = 4'hF;
        #2;
        chk("rereq_idle", outs(), d);
        @(negedge clk_neg_i); #2;
        chk("rereq_issue", outs(), xo(0, 0, 0, 0, 0, 1, 0, 32'h904, 0, 32'hF));
        @(negedge clk_neg_i);
        bus.sram_rdata_i = 32'hBEEF0904;
        #2;
        chk("rereq_ack", outs(), xo(0, 0, 0, 1, 32'hBEEF0904, 0, 0, 0, 0, 32'hF));
        @(negedge clk_neg_i);
        bus.ext_req_i = 1'b0;
        #2;
        chk("rereq_drop", outs(), d);
        @(negedge clk_neg_i); #2;
        chk("rereq_back_idle", outs(), d);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dram_itf_arbiter.md
DRAM_ITF_ARBITER -- requirements
Module: dram_itf_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, 4, consecutive denied external-request cycles before the external port is forced; legal range 1..15.
REQ-002 clk_neg_i  in  1  inverted core clock; all state updates on its rising edge.
REQ-003 rst_neg_ni  in  1  reset, asynchronous, active-low.
REQ-004 core_req_i, core_we_i  in  1 each  core LSU request, write enable.
REQ-005 core_addr_i, core_wdata_i  in  32 each  core address, write data; core_be_i  in  4  byte enables.
REQ-006 core_gnt_o  out  1  core request accepted this cycle; core_rvalid_o  out  1  core read data valid; core_rdata_o  out  32.
REQ-007 ext_req_i, ext_we_i  in  1 each  external request, level, held until ack; ext_addr_i, ext_wdata_i  in  32; ext_be_i  in  4.
REQ-008 ext_ack_o  out  1  external transaction complete; ext_rdata_o  out  32.
REQ-009 sram_req_o, sram_we_o  out  1; sram_addr_o, sram_wdata_o  out  32; sram_be_o  out  4; sram_rdata_i  in  32, valid one cycle after sram_req_o.

Function
REQ-010 FSM states SHALL be IDLE, EXT_ISSUE, EXT_ACK, EXT_DROP.
REQ-011 IDLE: core_gnt_o = core_req_i & ~ext_win; ext_win = ext_req_i & (~core_req_i | starve_hit).
REQ-012 IDLE with ext_win: capture ext addr/we/be/wdata into registers; next state EXT_ISSUE.
REQ-013 EXT_ISSUE: sram_* driven from captured ext registers, sram_req_o=1, core_gnt_o=0; next EXT_ACK.
REQ-014 EXT_ACK: ext_ack_o=1 for exactly one cycle, ext_rdata_o=sram_rdata_i; core may be granted; next EXT_DROP.
REQ-015 EXT_DROP: core may be granted; ext_req_i ignored; return to IDLE when ext_req_i=0 (prevents re-issue of held request).
REQ-016 When core granted, sram_* SHALL pass core fields combinationally, sram_req_o=1; otherwise sram_req_o=0 except EXT_ISSUE; sram_wdata_o=0, sram_we_o=0, sram_be_o=4'hF when idle.
REQ-017 core_rvalid_o SHALL assert one cycle after every core grant with we=0; core_rdata_o=sram_rdata_i.
REQ-018 Latency: core grant-to-rvalid 1 cycle; ext request seen in IDLE at cycle N -> issue N+1 -> ext_ack_o at N+2.
REQ-019 Writes from either port SHALL take the same state sequence as reads; ext_ack_o also completes writes.
REQ-020 Simultaneous core and ext request in IDLE without starve_hit: core wins, ext waits.
REQ-021 ext_ack_o and core_rvalid_o SHALL never both be driven from the same SRAM read cycle.

Reset
REQ-022 On rst_neg_ni=0: state IDLE, starve counter 0, rvalid flag 0, captured ext registers 0; all outputs 0 except sram_be_o=4'hF.
REQ-023 Reset mid-transaction SHALL abandon it with no ack; ext master re-requests after reset release.

Configuration
REQ-024 Macro DRAM_ARB_STARVE_GUARD_EN defined: 4-bit counter increments each IDLE cycle with ext_req_i & core_req_i, saturates at STARVE_MAX, clears on entry to EXT_ISSUE; starve_hit = (count == STARVE_MAX).
REQ-025 Macro undefined: no counter; starve_hit tied 0; ext served only in IDLE cycles without core_req_i.

Verification
REQ-026 Core read 0x100, no ext -> core_gnt_o same cycle, core_rvalid_o next cycle with SRAM word at 0x100.
REQ-027 Ext write 0x200=0xDEADBEEF, be=0xF, core idle -> sram write at N+1, ext_ack_o pulse at N+2, single write despite req held 2 extra cycles.
REQ-028 Ext read with core_req_i continuously high, guard enabled, STARVE_MAX=4 -> core granted 4 cycles, then EXT_ISSUE, ext_ack_o 2 cycles later.
REQ-029 Same stimulus with guard disabled -> ext_ack_o never asserted while core_req_i high; ack 2 cycles after core_req_i drops.
REQ-030 rst_neg_ni asserted during EXT_ISSUE -> no ext_ack_o, state IDLE, all outputs at reset values.
